// File: rtl/multicycle_control.sv
// multicycle_control: state sequencer for the multi-cycle MIPS datapath.
// Steps FETCH -> DECODE -> EXEC/MEM -> WB and drives every datapath select
// and enable. Memory phases wait on mem_ready. Unsupported opcodes park the
// machine in a sticky HALT that only clr_n can leave.
// Optional feature: define MC_PERF_CNT_EN to add the retired-instruction
// counter output retired[CNT_W-1:0].
module multicycle_control #(
    parameter int CNT_W    = 32,
    parameter int ALU_OP_W = 2
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                run,
    input  logic [5:0]          op,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic [1:0]          pc_source,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dest,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
`ifdef MC_PERF_CNT_EN
    output logic [CNT_W-1:0]    retired,
`endif
    output logic                halted
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(2'b00);
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(2'b01);
    localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(2'b10);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADDR,
        MEM_RD,
        LW_WB,
        MEM_WR,
        EXEC_R,
        R_WB,
        EXEC_I,
        I_WB,
        BRANCH,
        JUMP,
        HALT
    } state_t;

    state_t state;

    // The zero flag only qualifies pc_write_cond inside the datapath; the
    // sequencer itself never branches on it.
    logic unused_zero;
    assign unused_zero = zero;

    // State register: sequencing through the instruction phases.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:    if (run && mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= MEM_ADDR;
                        OP_R:         state <= EXEC_R;
                        OP_BEQ:       state <= BRANCH;
                        OP_J:         state <= JUMP;
                        OP_ADDI:      state <= EXEC_I;
                        default:      state <= HALT;
                    endcase
                end
                MEM_ADDR: state <= (op == OP_SW) ? MEM_WR : MEM_RD;
                MEM_RD:   if (mem_ready) state <= LW_WB;
                MEM_WR:   if (mem_ready) state <= FETCH;
                EXEC_R:   state <= R_WB;
                EXEC_I:   state <= I_WB;
                LW_WB, R_WB, I_WB, BRANCH, JUMP: state <= FETCH;
                HALT:     state <= HALT;
                default:  state <= FETCH;
            endcase
        end
    end

    // Output decode from state; FETCH strobes are qualified by run and
    // mem_ready so the IR and PC load in the cycle the read completes.
    // Everything is forced low while clr_n is held so an aborted write
    // drops its request at once.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 2'b00;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dest      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALU_ADD;
        halted        = 1'b0;
        if (clr_n) begin
            case (state)
                FETCH: begin
                    if (run) begin
                        mem_read  = 1'b1;
                        alu_src_b = 2'b01;
                        ir_write  = mem_ready;
                        pc_write  = mem_ready;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'b11;
                end
                MEM_ADDR, EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                LW_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    reg_dest  = 1'b1;
                end
                I_WB: begin
                    reg_write = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                HALT: begin
                    halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    // An instruction retires on the cycle its last phase hands back to FETCH.
    logic retire;
    assign retire = (state == LW_WB) || (state == R_WB) || (state == I_WB) ||
                    (state == BRANCH) || (state == JUMP) ||
                    ((state == MEM_WR) && mem_ready);

    // Retired-instruction counter, wraps naturally at full scale.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. Builds each instruction's expected
// per-cycle control trace from its opcode class and planned memory waits,
// then drives randomized instruction streams and compares every cycle.
module tb_multicycle_control;

    localparam int TB_CNT_W = 4;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       run;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dest, mem_to_reg, reg_write, alu_src_a, halted;
    logic [1:0] pc_source, alu_src_b, alu_op;
`ifdef MC_PERF_CNT_EN
    logic [TB_CNT_W-1:0] retired;
`endif

    always #5 clk = ~clk;

    multicycle_control #(.CNT_W(TB_CNT_W), .ALU_OP_W(2)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .op(op), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dest(reg_dest),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op),
`ifdef MC_PERF_CNT_EN
        .retired(retired),
`endif
        .halted(halted)
    );

    logic [16:0] obs;
    assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                  ir_write, reg_dest, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                  alu_op, halted};

    int total = 0;
    int bad   = 0;
    int ret_m = 0;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word in the same field order as obs.
    function automatic logic [16:0] ow(input bit pcw, input bit pcc, input logic [1:0] pcs,
                                       input bit iod, input bit mr, input bit mw,
                                       input bit irw, input bit rd, input bit m2r,
                                       input bit rw, input bit asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input bit h);
        return {pcw, pcc, pcs, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, h};
    endfunction

    function automatic bit legal(input logic [5:0] o);
        return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
               o == 6'b001000 || o == 6'b000100 || o == 6'b000010;
    endfunction

    // One clock: apply inputs, check outputs mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input logic [16:0] e, input bit rdy, input bit r);
        mem_ready = rdy;
        run       = r;
        zero      = 1'($urandom);
        @(negedge clk);
        chk(tag, {15'd0, obs}, {15'd0, e});
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse issued mid-cycle; outputs must drop at once.
    task automatic do_reset();
        run       = 1'b1;
        mem_ready = 1'b1;
        clr_n     = 1'b0;
        #1;
        chk("rst_now", {15'd0, obs}, 32'd0);
        @(negedge clk);
        chk("rst_hold", {15'd0, obs}, 32'd0);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        ret_m = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc("idle", 17'd0, 1'($urandom), 1'b0);
    endtask

    // Expand one instruction into its expected trace. fw/mw are wait cycles
    // in fetch and in the data-memory phase; abort resets during a store.
    task automatic instr(input logic [5:0] opc, input int fw, input int mw, input bit abort);
        logic [16:0] f_wait, f_done, dec, agen, rdw, wrw;
        f_wait = ow(0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,2'b00,0);
        f_done = ow(1,0,2'b00,0,1,0,1,0,0,0,0,2'b01,2'b00,0);
        dec    = ow(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,2'b00,0);
        agen   = ow(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b00,0);
        rdw    = ow(0,0,2'b00,1,1,0,0,0,0,0,0,2'b00,2'b00,0);
        wrw    = ow(0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,2'b00,0);
        op = opc;
`ifdef MC_PERF_CNT_EN
        chk("retired", 32'(retired), 32'(ret_m));
`endif
        repeat (fw) cyc("fetch_wait", f_wait, 1'b0, 1'b1);
        cyc("fetch", f_done, 1'b1, 1'b1);
        cyc("decode", dec, 1'($urandom), 1'($urandom));
        case (opc)
            6'b100011: begin
                cyc("lw_addr", agen, 1'($urandom), 1'($urandom));
                repeat (mw) cyc("lw_wait", rdw, 1'b0, 1'($urandom));
                cyc("lw_rd", rdw, 1'b1, 1'($urandom));
                cyc("lw_wb", ow(0,0,2'b00,0,0,0,0,0,1,1,0,2'b00,2'b00,0), 1'($urandom), 1'($urandom));
            end
            6'b101011: begin
                cyc("sw_addr", agen, 1'($urandom), 1'($urandom));
                if (abort) begin
                    cyc("sw_wait", wrw, 1'b0, 1'b1);
                    do_reset();
                    return;
                end
                repeat (mw) cyc("sw_wait", wrw, 1'b0, 1'($urandom));
                cyc("sw_wr", wrw, 1'b1, 1'($urandom));
            end
            6'b000000: begin
                cyc("r_exec", ow(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,2'b10,0), 1'($urandom), 1'($urandom));
                cyc("r_wb", ow(0,0,2'b00,0,0,0,0,1,0,1,0,2'b00,2'b00,0), 1'($urandom), 1'($urandom));
            end
            6'b001000: begin
                cyc("i_exec", agen, 1'($urandom), 1'($urandom));
                cyc("i_wb", ow(0,0,2'b00,0,0,0,0,0,0,1,0,2'b00,2'b00,0), 1'($urandom), 1'($urandom));
            end
            6'b000100: cyc("beq", ow(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,2'b01,0), 1'($urandom), 1'($urandom));
            6'b000010: cyc("jump", ow(1,0,2'b10,0,0,0,0,0,0,0,0,2'b00,2'b00,0), 1'($urandom), 1'($urandom));
            default: begin
                repeat (20) cyc("halt", ow(0,0,2'b00,0,0,0,0,0,0,0,0,2'b00,2'b00,1), 1'($urandom), 1'b1);
                do_reset();
                return;
            end
        endcase
        ret_m = (ret_m + 1) % (1 << TB_CNT_W);
    endtask

    function automatic logic [5:0] rand_legal();
        logic [5:0] tbl [6];
        tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
        return tbl[$urandom_range(0, 5)];
    endfunction

    initial begin
        logic [5:0] o;
        clr_n = 1'b0; run = 1'b1; op = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset_out", {15'd0, obs}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;

        // Directed scenarios.
        instr(6'b000000, 0, 0, 1'b0);   // R-type, zero-wait
        instr(6'b100011, 0, 2, 1'b0);   // lw with two read waits
        instr(6'b000100, 0, 0, 1'b0);   // beq twice
        instr(6'b000100, 1, 0, 1'b0);
        instr(6'b101011, 0, 0, 1'b1);   // reset during store
        instr(6'b111111, 0, 0, 1'b0);   // illegal opcode, then reset
        idle(5);
        instr(6'b000010, 0, 0, 1'b0);   // j, addi, sw
        instr(6'b001000, 0, 0, 1'b0);
        instr(6'b101011, 0, 1, 1'b0);
`ifdef MC_PERF_CNT_EN
        chk("retired_3", 32'(retired), 32'd3);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 300; n++) begin
            int k;
            k = int'($urandom_range(0, 19));
            if (k == 0) begin
                do o = 6'($urandom); while (legal(o));
                instr(o, int'($urandom_range(0, 2)), 0, 1'b0);
            end else if (k == 1) begin
                instr(6'b101011, int'($urandom_range(0, 2)), 0, 1'b1);
            end else begin
                if (k < 5) idle(int'($urandom_range(1, 3)));
                instr(rand_legal(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'b0);
            end
        end
`ifdef MC_PERF_CNT_EN
        chk("retired_end", 32'(retired), 32'(ret_m));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
